// File: rtl/fc_pkg.sv
// Shared types and the requantisation helper for the fully-connected engine.
// Build option FC_SAT_EN: saturating narrowing instead of wrap-around truncation.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT
  } fcState_e;

  // Arithmetic shift, optional ReLU, then narrow to dw bits (sign-extended result).
  function automatic logic signed [63:0] fcRequant(
    input logic signed [63:0] acc,
    input logic        [4:0]  shift,
    input logic               relu,
    input int                 dw
  );
    logic signed [63:0] r;
    r = acc >>> shift;
    if (relu && (r < 0)) r = '0;
`ifdef FC_SAT_EN
    begin
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
    end
`else
    r = (r <<< (64 - dw)) >>> (64 - dw);
`endif
    return r;
  endfunction

endpackage

// File: rtl/fc_engine_p_if.sv
// Buffer-load and result-stream signals of fc_engine_p; slave is the engine side.
interface fc_engine_p_if #(
  parameter int DW      = 8,
  parameter int LANES   = 4,
  parameter int IN_MAX  = 256,
  parameter int OUT_MAX = 128
);
  localparam int TILES = (OUT_MAX + LANES - 1) / LANES;
  localparam int WA_W  = $clog2(IN_MAX * TILES);
  localparam int IA_W  = $clog2(IN_MAX);

  logic                  wbuf_wren_i;
  logic [WA_W-1:0]       wbuf_wrptr_i;
  logic [LANES*DW-1:0]   wbuf_wdata_i;
  logic                  ifmap_wren_i;
  logic [IA_W-1:0]       ifmap_wrptr_i;
  logic [DW-1:0]         ifmap_wdata_i;
  logic [DW-1:0]         psum_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  last_o;

  modport slave (
    input  wbuf_wren_i, wbuf_wrptr_i, wbuf_wdata_i,
    input  ifmap_wren_i, ifmap_wrptr_i, ifmap_wdata_i,
    input  ready_i,
    output psum_o, valid_o, last_o
  );

  modport master (
    output wbuf_wren_i, wbuf_wrptr_i, wbuf_wdata_i,
    output ifmap_wren_i, ifmap_wrptr_i, ifmap_wdata_i,
    output ready_i,
    input  psum_o, valid_o, last_o
  );
endinterface

// File: rtl/fc_mac_lane.sv
// One signed multiply-accumulate lane; the accumulator wraps at AW bits.
module fc_mac_lane #(
  parameter int DW = 8,
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_w,
  input  logic signed [DW-1:0] i_x,
  output logic signed [AW-1:0] o_acc
);
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   r_acc;

  assign w_prod = $signed({{DW{i_w[DW-1]}}, i_w}) * $signed({{DW{i_x[DW-1]}}, i_x});

  always_ff @(posedge clk) begin
    if (rst || i_clr) r_acc <= '0;
    else if (i_en)    r_acc <= r_acc + {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/fc_engine_p.sv
// Fully-connected layer engine: LANES neurons per tile, streamed one per beat.
// Build option FC_SAT_EN selects saturating narrowing (see fc_pkg::fcRequant).
module fc_engine_p
  import fc_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 24,
  parameter int IN_MAX  = 256,
  parameter int OUT_MAX = 128,
  parameter int LANES   = 4,
  localparam int IN_W   = $clog2(IN_MAX + 1),
  localparam int OUT_W  = $clog2(OUT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IN_W-1:0]  in_node_num_i,
  input  logic [OUT_W-1:0] out_node_num_i,
  input  logic [4:0]       shift_i,
  input  logic             relu_en_i,
  output logic             busy_o,
  fc_engine_p_if.slave     bus
);
  localparam int TILES  = (OUT_MAX + LANES - 1) / LANES;
  localparam int WA_W   = $clog2(IN_MAX * TILES);
  localparam int IA_W   = $clog2(IN_MAX);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  fcState_e            r_state;
  logic [IN_W-1:0]     r_inNum;
  logic [4:0]          r_shift;
  logic                r_relu;
  logic [IN_W-1:0]     r_j;
  logic [WA_W-1:0]     r_wAddr;
  logic                r_drain;
  logic [OUT_W-1:0]    r_remain;
  logic [OUT_W-1:0]    r_lane;
  logic                r_macEn;
  logic [DW-1:0]       r_psum;
  logic                r_valid;
  logic                r_last;
  logic                r_busy;

  logic [LANES*DW-1:0] r_wbuf [2**WA_W];
  logic [DW-1:0]       r_ifmap [2**IA_W];
  logic [LANES*DW-1:0] r_wRd;
  logic [DW-1:0]       r_xRd;

  logic signed [AW-1:0] w_acc [LANES];
  logic [DW-1:0]        w_req [LANES];
  logic                 w_startOk;
  logic                 w_lastTile;
  logic [OUT_W-1:0]     w_tileN;
  logic [OUT_W-1:0]     w_nextLane;
  logic                 w_moreLanes;
  logic                 w_accept;
  logic                 w_clr;

  assign w_startOk   = start_i
                     && (in_node_num_i != '0) && (in_node_num_i <= IN_W'(IN_MAX))
                     && (out_node_num_i != '0) && (out_node_num_i <= OUT_W'(OUT_MAX));
  assign w_lastTile  = (r_remain <= OUT_W'(LANES));
  assign w_tileN     = w_lastTile ? r_remain : OUT_W'(LANES);
  assign w_nextLane  = r_lane + OUT_W'(1);
  assign w_moreLanes = (w_nextLane < w_tileN);
  assign w_accept    = r_valid && bus.ready_i;
  // Accumulators restart on a layer start and when moving on to the next tile.
  assign w_clr       = ((r_state == IDLE) && w_startOk)
                     || ((r_state == OUT) && w_accept && !w_moreLanes && !w_lastTile);

  always_ff @(posedge clk) begin
    if (bus.wbuf_wren_i && !r_busy)  r_wbuf[bus.wbuf_wrptr_i]   <= bus.wbuf_wdata_i;
    if (bus.ifmap_wren_i && !r_busy) r_ifmap[bus.ifmap_wrptr_i] <= bus.ifmap_wdata_i;
    r_wRd <= r_wbuf[r_wAddr];
    r_xRd <= r_ifmap[r_j[IA_W-1:0]];
  end

  // Operands arrive one cycle after their read is issued, so the enable trails MAC.
  always_ff @(posedge clk) begin
    if (rst) r_macEn <= 1'b0;
    else     r_macEn <= (r_state == MAC);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_mac_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (r_macEn),
      .i_w   (r_wRd[l*DW +: DW]),
      .i_x   (r_xRd),
      .o_acc (w_acc[l])
    );
    assign w_req[l] = DW'(fcRequant($signed({{(64-AW){w_acc[l][AW-1]}}, w_acc[l]}),
                                    r_shift, r_relu, DW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_inNum  <= '0;
      r_shift  <= '0;
      r_relu   <= 1'b0;
      r_j      <= '0;
      r_wAddr  <= '0;
      r_drain  <= 1'b0;
      r_remain <= '0;
      r_lane   <= '0;
      r_psum   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startOk) begin
            r_inNum  <= in_node_num_i;
            r_shift  <= shift_i;
            r_relu   <= relu_en_i;
            r_remain <= out_node_num_i;
            r_j      <= '0;
            r_wAddr  <= '0;
            r_busy   <= 1'b1;
            r_state  <= MAC;
          end
        end
        MAC: begin
          // Weight words of consecutive tiles are contiguous, so the address just runs on.
          r_wAddr <= r_wAddr + WA_W'(1);
          if (r_j == r_inNum - IN_W'(1)) begin
            r_j     <= '0;
            r_drain <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_j <= r_j + IN_W'(1);
          end
        end
        DRAIN: begin
          if (!r_drain) begin
            r_drain <= 1'b1;
          end else begin
            r_psum  <= w_req[0];
            r_valid <= 1'b1;
            r_last  <= w_lastTile && (w_tileN == OUT_W'(1));
            r_lane  <= '0;
            r_state <= OUT;
          end
        end
        OUT: begin
          if (w_accept) begin
            if (w_moreLanes) begin
              r_lane <= w_nextLane;
              r_psum <= w_req[w_nextLane[LANE_W-1:0]];
              r_last <= w_lastTile && ((r_lane + OUT_W'(2)) == w_tileN);
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              if (w_lastTile) begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end else begin
                r_remain <= r_remain - OUT_W'(LANES);
                r_state  <= MAC;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign bus.psum_o  = r_psum;
  assign bus.valid_o = r_valid;
  assign bus.last_o  = r_last;
endmodule

// File: tb/tb_fc_engine_p.sv
// Self-checking bench for fc_engine_p: directed scenarios plus randomized layers
// compared beat-by-beat against a dot-product model of the layer.
module tb_fc_engine_p;
  localparam int DW      = 8;
  localparam int AW      = 24;
  localparam int IN_MAX  = 256;
  localparam int OUT_MAX = 128;
  localparam int LANES   = 4;
  localparam int IN_W    = $clog2(IN_MAX + 1);
  localparam int OUT_W   = $clog2(OUT_MAX + 1);

  typedef struct {
    longint v;
    bit     l;
  } beat_t;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [IN_W-1:0]  inNum = '0;
  logic [OUT_W-1:0] outNum = '0;
  logic [4:0]       shift = '0;
  logic             relu  = 1'b0;
  logic             busy;

  fc_engine_p_if #(.DW(DW), .LANES(LANES), .IN_MAX(IN_MAX), .OUT_MAX(OUT_MAX)) bus ();

  fc_engine_p #(.DW(DW), .AW(AW), .IN_MAX(IN_MAX), .OUT_MAX(OUT_MAX), .LANES(LANES)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .in_node_num_i  (inNum),
    .out_node_num_i (outNum),
    .shift_i        (shift),
    .relu_en_i      (relu),
    .busy_o         (busy),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     nChecks = 0;
  int     nPass   = 0;
  int     xs [IN_MAX];
  int     wm [OUT_MAX][IN_MAX];
  beat_t  expQ [$];
  int     expIdx = 0;
  int     beatCyc [$];
  longint beatVal [$];
  bit     beatLast [$];
  int     cycStart = 0;
  bit     monEn = 1'b0;
  int     readyMode = 0;
  bit     readyManual = 1'b0;
  bit     stallPend = 1'b0;
  longint heldPsum = 0;
  bit     heldLast = 1'b0;
  int     doneCyc = 0;
  int     busyAt1 = 0;
  int     waitCnt = 0;
  int     base = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain dot product, AW-bit wrap, shift, ReLU, then narrow to DW.
  function automatic longint modelNeuron(int o, int n, int sh, bit rl);
    longint acc = 0;
    for (int j = 0; j < n; j++) acc += longint'(wm[o][j]) * longint'(xs[j]);
    acc = acc & 64'hFFFFFF;
    if (acc >= 8388608) acc -= 16777216;
    acc = acc >>> sh;
    if (rl && acc < 0) acc = 0;
`ifdef FC_SAT_EN
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
`else
    acc = acc & 255;
    if (acc >= 128) acc -= 256;
`endif
    return acc;
  endfunction

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       bus.ready_i = 1'b1;
      1:       bus.ready_i = ($urandom_range(0, 3) != 0);
      default: bus.ready_i = readyManual;
    endcase
  end

  // Compare process: every accepted beat against the model, every stalled cycle for stability.
  always @(negedge clk) begin
    if (!monEn || rst) begin
      stallPend = 1'b0;
    end else begin
      if (stallPend) begin
        checkOutput("hold valid", longint'(bus.valid_o), 1);
        checkOutput("hold psum", longint'($signed(bus.psum_o)), heldPsum);
        checkOutput("hold last", longint'(bus.last_o), longint'(heldLast));
      end
      stallPend = 1'b0;
      if (bus.valid_o && bus.ready_i) begin
        if (expIdx >= expQ.size()) begin
          checkOutput("unexpected beat", 1, 0);
        end else begin
          checkOutput("beat psum", longint'($signed(bus.psum_o)), expQ[expIdx].v);
          checkOutput("beat last", longint'(bus.last_o), longint'(expQ[expIdx].l));
          expIdx++;
        end
        beatCyc.push_back(cyc - cycStart);
        beatVal.push_back(longint'($signed(bus.psum_o)));
        beatLast.push_back(bus.last_o);
      end else if (bus.valid_o) begin
        stallPend = 1'b1;
        heldPsum  = longint'($signed(bus.psum_o));
        heldLast  = bus.last_o;
      end
    end
  end

  task automatic loadIfmap(input int n);
    for (int j = 0; j < n; j++) begin
      bus.ifmap_wren_i  = 1'b1;
      bus.ifmap_wrptr_i = 8'(j);
      bus.ifmap_wdata_i = 8'(xs[j]);
      tick();
    end
    bus.ifmap_wren_i = 1'b0;
  endtask

  task automatic loadWeights(input int n, input int o);
    int tiles = (o + LANES - 1) / LANES;
    logic [LANES*DW-1:0] word;
    for (int t = 0; t < tiles; t++) begin
      for (int j = 0; j < n; j++) begin
        for (int l = 0; l < LANES; l++) begin
          if (t * LANES + l < o) word[l*DW +: DW] = 8'(wm[t*LANES+l][j]);
          else                   word[l*DW +: DW] = 8'($urandom);
        end
        bus.wbuf_wren_i  = 1'b1;
        bus.wbuf_wrptr_i = 13'(t * n + j);
        bus.wbuf_wdata_i = word;
        tick();
      end
    end
    bus.wbuf_wren_i = 1'b0;
  endtask

  // Runs one layer to completion; optionally tries an ifmap write while busy.
  task automatic applyStimulus(input int n, input int o, input int sh, input bit rl, input bit junk);
    int tiles = (o + LANES - 1) / LANES;
    int lim   = tiles * (n + 8) + 40 * o + 60;
    int k     = 0;
    for (int i = 0; i < o; i++) expQ.push_back('{modelNeuron(i, n, sh, rl), (i == o - 1)});
    base     = beatVal.size();
    inNum    = IN_W'(n);
    outNum   = OUT_W'(o);
    shift    = 5'(sh);
    relu     = rl;
    start    = 1'b1;
    cycStart = cyc;
    tick();
    start   = 1'b0;
    busyAt1 = 0;
    doneCyc = -1;
    while (k < lim) begin
      @(negedge clk);
      k++;
      if (k == 1) busyAt1 = int'(busy);
      if (junk && k == 2) begin
        bus.ifmap_wren_i  = 1'b1;
        bus.ifmap_wrptr_i = '0;
        bus.ifmap_wdata_i = 8'h55;
      end
      if (junk && k == 3) bus.ifmap_wren_i = 1'b0;
      if (!busy) begin
        doneCyc = cyc - cycStart;
        break;
      end
    end
    bus.ifmap_wren_i = 1'b0;
    checkOutput("layer finishes within budget", longint'(doneCyc >= 0), 1);
    checkOutput("all expected beats delivered", expIdx, expQ.size());
    tick();
  endtask

  task automatic setScenario1();
    xs[0] = 1; xs[1] = 2; xs[2] = 3;
    wm[0][0] = 1;  wm[0][1] = 1; wm[0][2] = 1;
    wm[1][0] = -1; wm[1][1] = 0; wm[1][2] = 2;
  endtask

  initial begin
    int badIn [4];
    int badOut [4];
    int n;
    int o;
    int lastCnt;
    longint expSat;
    badIn  = '{0, 257, 3, 3};
    badOut = '{2, 2, 0, 129};
    bus.wbuf_wren_i   = 1'b0;
    bus.wbuf_wrptr_i  = '0;
    bus.wbuf_wdata_i  = '0;
    bus.ifmap_wren_i  = 1'b0;
    bus.ifmap_wrptr_i = '0;
    bus.ifmap_wdata_i = '0;

    repeat (3) tick();
    @(negedge clk);
    checkOutput("reset busy_o", longint'(busy), 0);
    checkOutput("reset valid_o", longint'(bus.valid_o), 0);
    checkOutput("reset last_o", longint'(bus.last_o), 0);
    checkOutput("reset psum_o", longint'(bus.psum_o), 0);
    tick();
    rst   = 1'b0;
    monEn = 1'b1;
    tick();

    $display("[TB] scenario 1: in=3 out=2");
    setScenario1();
    checkOutput("model neuron0", modelNeuron(0, 3, 0, 0), 6);
    checkOutput("model neuron1", modelNeuron(1, 3, 0, 0), 5);
    loadIfmap(3);
    loadWeights(3, 2);
    applyStimulus(3, 2, 0, 0, 0);
    checkOutput("s1 beat count", beatVal.size() - base, 2);
    checkOutput("s1 beat0 value", beatVal[base], 6);
    checkOutput("s1 beat1 value", beatVal[base+1], 5);
    checkOutput("s1 beat0 cycle", beatCyc[base], 6);
    checkOutput("s1 beat1 cycle", beatCyc[base+1], 7);
    checkOutput("s1 beat0 last", longint'(beatLast[base]), 0);
    checkOutput("s1 beat1 last", longint'(beatLast[base+1]), 1);
    checkOutput("s1 busy at cycle 1", busyAt1, 1);
    checkOutput("s1 busy low cycle", doneCyc, 8);

    $display("[TB] scenario 5: consumer stall on first beat");
    readyMode   = 2;
    readyManual = 1'b0;
    tick();
    fork
      applyStimulus(3, 2, 0, 0, 0);
      begin
        waitCnt = 0;
        while (waitCnt < 40 && !bus.valid_o) begin
          @(negedge clk);
          waitCnt++;
        end
        checkOutput("stall first beat appears", longint'(bus.valid_o), 1);
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall psum held", longint'($signed(bus.psum_o)), 6);
        end
        readyManual = 1'b1;
      end
    join
    readyMode = 0;
    checkOutput("stall beat count", beatVal.size() - base, 2);
    checkOutput("stall beat0 value", beatVal[base], 6);
    checkOutput("stall beat1 value", beatVal[base+1], 5);

    $display("[TB] reset mid-MAC and ignored starts");
    monEn  = 1'b0;
    inNum  = 9'd3;
    outNum = 8'd2;
    shift  = '0;
    relu   = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    checkOutput("busy before reset", longint'(busy), 1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("reset mid-MAC valid_o", longint'(bus.valid_o), 0);
    checkOutput("reset mid-MAC busy_o", longint'(busy), 0);
    tick();
    rst   = 1'b0;
    monEn = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      inNum  = IN_W'(badIn[b]);
      outNum = OUT_W'(badOut[b]);
      start  = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      checkOutput("bad start ignored", longint'(busy), 0);
      tick();
    end

    $display("[TB] re-start scenario 1 without reload");
    applyStimulus(3, 2, 0, 0, 1);
    checkOutput("restart beat count", beatVal.size() - base, 2);
    checkOutput("restart beat0 value", beatVal[base], 6);
    checkOutput("restart beat1 value", beatVal[base+1], 5);

    $display("[TB] scenario 2: in=120 narrowing");
    for (int j = 0; j < 120; j++) begin
      xs[j]    = 3;
      wm[0][j] = 3;
    end
`ifdef FC_SAT_EN
    expSat = 127;
`else
    expSat = 56;
`endif
    checkOutput("model 1080 narrowed", modelNeuron(0, 120, 0, 0), expSat);
    checkOutput("model 1080 shift4", modelNeuron(0, 120, 4, 0), 67);
    loadIfmap(120);
    loadWeights(120, 1);
    applyStimulus(120, 1, 0, 0, 0);
    checkOutput("s2 narrowed value", beatVal[base], expSat);
    applyStimulus(120, 1, 4, 0, 0);
    checkOutput("s2 shift4 value", beatVal[base], 67);

    $display("[TB] scenario 3: ReLU");
    for (int j = 0; j < 4; j++) begin
      xs[j]    = 2;
      wm[0][j] = -1;
    end
    loadIfmap(4);
    loadWeights(4, 1);
    applyStimulus(4, 1, 0, 0, 0);
    checkOutput("s3 relu off", beatVal[base], -8);
    applyStimulus(4, 1, 0, 1, 0);
    checkOutput("s3 relu on", beatVal[base], 0);

    $display("[TB] scenario 4: out=6 across two tiles");
    for (int j = 0; j < 5; j++) begin
      xs[j] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 6; i++) wm[i][j] = int'($urandom_range(0, 255)) - 128;
    end
    loadIfmap(5);
    loadWeights(5, 6);
    applyStimulus(5, 6, 3, 0, 0);
    checkOutput("s4 beat count", beatVal.size() - base, 6);
    lastCnt = 0;
    for (int i = base; i < beatLast.size(); i++) lastCnt += int'(beatLast[i]);
    checkOutput("s4 single last", lastCnt, 1);
    checkOutput("s4 last on sixth", longint'(beatLast[base+5]), 1);
    checkOutput("s4 tile gap", beatCyc[base+4] - beatCyc[base+3], 8);

    $display("[TB] randomized layers");
    readyMode = 1;
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 48));
      o = int'($urandom_range(1, 14));
      for (int j = 0; j < n; j++) begin
        xs[j] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < o; i++) wm[i][j] = int'($urandom_range(0, 255)) - 128;
      end
      loadIfmap(n);
      loadWeights(n, o);
      applyStimulus(n, o, int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), 0);
      checkOutput("random beat count", beatVal.size() - base, o);
    end
    readyMode = 0;
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
